// File: rtl/conv1d_relu_stream_if.sv
// Stream and coefficient-port bundle for conv1d_relu_stream.
// The master drives samples and coefficients; the slave returns activations.
interface conv1d_relu_stream_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    coef_we;
    logic [1:0]              coef_addr;
    logic signed [WIDTH-1:0] coef_data;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        output in_valid, in_data, in_last,
        output coef_we, coef_addr, coef_data,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last,
        input  coef_we, coef_addr, coef_data,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv1d_relu_stream.sv
// Streaming 3-tap convolution with bias, floor shift, saturation and ReLU.
// Window capture, product stage, then sum/saturate stage: 2-edge latency.
module conv1d_relu_stream #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic clk,
    input  logic rst,
    conv1d_relu_stream_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_e;

    fill_e state_q, state_d;
    logic  issue;

    logic signed [WIDTH-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [WIDTH-1:0] coef_q [4];
    logic signed [WIDTH-1:0] coef_d [4];
    logic signed [WIDTH-1:0] cuse_q [4];
    logic                    s0_valid_q, s0_valid_d, s0_last_q, s0_last_d;

    logic signed [PW-1:0]    p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic signed [WIDTH-1:0] bias_q, bias_d;
    logic                    p_valid_q, p_valid_d, p_last_q, p_last_d;

    logic signed [AW-1:0]    acc, y;
    logic signed [WIDTH-1:0] res;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;

    // Fill tracking: output only once three samples of one sequence are held
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                EMPTY: state_d = ONE;
                ONE:   state_d = TWO;
                TWO: begin
                    state_d = FULL;
                    issue   = 1'b1;
                end
                default: begin
                    state_d = FULL;
                    issue   = 1'b1;
                end
            endcase
            if (bus.in_last) state_d = EMPTY;
        end
    end

    // Window shift and coefficient writes; cuse_q lags one edge so a
    // sample accepted alongside a write still sees the old coefficients
    always_comb begin
        x0_d       = x0_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        s0_valid_d = issue;
        s0_last_d  = issue & bus.in_last;
        if (bus.in_valid) begin
            x0_d = x1_q;
            x1_d = x2_q;
            x2_d = bus.in_data;
        end
        for (int i = 0; i < 4; i++) coef_d[i] = coef_q[i];
        if (bus.coef_we) coef_d[bus.coef_addr] = bus.coef_data;
    end

    // Product stage, bias carried alongside so it matches the weights used
    always_comb begin
        p0_d      = p0_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        bias_d    = bias_q;
        p_valid_d = s0_valid_q;
        p_last_d  = s0_last_q;
        if (s0_valid_q) begin
            p0_d   = PW'(cuse_q[0]) * PW'(x0_q);
            p1_d   = PW'(cuse_q[1]) * PW'(x1_q);
            p2_d   = PW'(cuse_q[2]) * PW'(x2_q);
            bias_d = cuse_q[3];
        end
    end

    // Full-precision sum, floor shift, clamp to max, negatives to zero
    always_comb begin
        acc = AW'(p0_q) + AW'(p1_q) + AW'(p2_q)
            + (AW'(bias_q) <<< FRAC);
        y   = acc >>> FRAC;
        if (y[AW-1]) begin
            res = '0;
        end else if (|y[AW-2:WIDTH-1]) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res = y[WIDTH-1:0];
        end
        out_valid_d = p_valid_q;
        out_last_d  = p_last_q;
        out_data_d  = out_data_q;
        if (p_valid_q) out_data_d = res;
    end

    // All state registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                coef_q[i] <= '0;
                cuse_q[i] <= '0;
            end
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            bias_q      <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            for (int i = 0; i < 4; i++) begin
                coef_q[i] <= coef_d[i];
                cuse_q[i] <= coef_q[i];
            end
            s0_valid_q  <= s0_valid_d;
            s0_last_q   <= s0_last_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            bias_q      <= bias_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: doc/conv1d_relu_stream.md
Name: conv1d_relu_stream

Overview:
- Streaming 3-tap 1-D convolution with bias, saturation and ReLU, in signed fixed point.
- Sits directly upstream of the 3-wide max-pooling stage in the ECG CNN datapath and produces the activation samples that stage consumes.
- Valid-only stream (no backpressure). Coefficients are loaded through a simple write port.

Parameters:
- WIDTH, 32, sample/coefficient/output width, signed two's complement.
- FRAC, 16, fractional bits (default Q16.16). Applies to inputs, weights, bias and output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  WIDTH  signed input sample.
- in_last  in  1  qualifies in_valid; marks the final sample of a sequence (beat).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  2  0=w0 (oldest tap), 1=w1, 2=w2 (newest tap), 3=bias.
- coef_data  in  WIDTH  signed coefficient value.
- out_valid  out  1  one-cycle pulse per output sample.
- out_data  out  WIDTH  signed result, always >= 0.
- out_last  out  1  marks the output produced by the in_last sample.

Behaviour:
- Reset (rst=0 at an edge):
  - out_valid=0, out_data=0, out_last=0.
  - Window x0..x2=0, fill count=0, pipeline valids cleared.
  - All four coefficients cleared to 0.
  - Reset mid-stream discards in-flight results: no out_valid may appear after reset from pre-reset samples.
- Window:
  - Each accepted sample (in_valid=1) shifts x0<=x1, x1<=x2, x2<=in_data.
  - in_valid=0 cycles are bubbles; window and fill count hold.
- Fill state machine:
  - States: EMPTY -> ONE -> TWO -> FULL, advancing on each accepted sample; FULL stays FULL.
  - An output is issued only when the accepted sample leaves the window FULL (valid convolution, no padding).
  - A sequence of N>=3 samples yields N-2 outputs.
- in_last handling:
  - The accepted in_last sample is processed normally: it issues an output if the window is full.
  - After that sample the state returns to EMPTY, so the next sample starts a new sequence with no mixing across sequences.
  - If in_last arrives before the window is full, no output is issued and the state returns to EMPTY.
- Arithmetic:
  - acc = w0*x0 + w1*x1 + w2*x2 + (bias <<< FRAC), computed at full precision (2*WIDTH+2 bits), no intermediate overflow.
  - y = acc >>> FRAC: arithmetic shift, floor rounding.
  - Saturate y to signed WIDTH range, then apply ReLU: y<0 -> 0.
  - As a result, out_data is in [0, 2^(WIDTH-1)-1].
- Pipeline and latency:
  - Stage 1 registers the three products; stage 2 registers sum, shift, saturation and ReLU.
  - A completing sample accepted at edge k produces out_valid=1 and out_data after edge k+2, held for exactly one cycle.
  - out_last follows the same timing.
  - Full throughput: one output per cycle with continuous in_valid.
- Coefficients:
  - A write at edge k takes effect for samples accepted at edge k+1 or later.
  - Products already in the pipeline use the old values.
  - Writes are allowed at any time, including during streaming and in the same cycle as in_valid (that sample uses the old values).
- When out_valid=0, out_data holds its last value. Consumers must qualify on out_valid.

Test Plan:
- Basic convolution: load w0=w1=w2=65536 (1.0), bias=0; stream 65536, 131072, 196608, 262144 with in_valid=1 on consecutive cycles. Expect out_valid on 2 cycles: 393216 (6.0) two edges after the third sample, then 589824 (9.0). No output after the first two samples.
- ReLU and bias: w0=w1=w2=-65536, bias=32768 (0.5); stream three samples of 65536. Expect out_data=0 (raw -2.5) with out_valid=1. Then set all weights to 0 and bias=-65536; any valid window must give 0.
- Saturation: w0=w1=w2=0x7FFF0000; stream three samples of 0x7FFF0000. Expect out_data=0x7FFFFFFF.
- in_last and bubbles:
  - Stream 2 samples with in_last on the second: no output.
  - Then stream 3 samples with bubbles (in_valid=0) between them and in_last on the third: exactly one output, with out_last=1 two edges after the third sample, using only the new samples.
- Coefficient update mid-stream: with a continuous stream of 65536, change w2 from 1.0 to 2.0 at edge k. Outputs from samples accepted up to edge k stay 196608; outputs from samples after edge k are 262144.
- Reset mid-stream: assert rst=0 for one cycle one edge after a completing sample. Expect no out_valid afterwards, all outputs 0, coefficients 0. The next 3 samples give out_data=0 until new coefficients are loaded.
